// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration path.
package ov7670_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_FETCH,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_DELAY,
        ST_DONE,
        ST_FAULT
    } cfg_state_t;

    localparam logic [15:0] ROM_END        = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY      = 16'hFFF0;
    localparam logic [7:0]  REG_COM7       = 8'h12;
    localparam int unsigned COM7_RESET_BIT = 7;
    localparam logic [7:0]  OV7670_WR_ID   = 8'h42;
    localparam logic [7:0]  USR_ERR_ADDR   = 8'hFF;

    // A COM7 write with the reset bit set needs the long settle afterwards.
    function automatic logic is_com7_reset(input logic [7:0] r, input logic [7:0] v);
        return (r == REG_COM7) && v[COM7_RESET_BIT];
    endfunction

    // Full 3-phase write frame as the SCCB master shifts it out.
    function automatic logic [23:0] sccb_write_frame(input logic [7:0] r, input logic [7:0] v);
        return {OV7670_WR_ID, r, v};
    endfunction

endpackage

// File: rtl/sccb_cfg_scheduler_if.sv
// Request/completion bus between the configuration scheduler and the SCCB write master.
interface sccb_cfg_scheduler_if;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_reg;
    logic [7:0] m_val;
    logic       m_done;
    logic       m_nack;

    modport master (
        output m_valid, m_reg, m_val,
        input  m_ready, m_done, m_nack
    );

    modport slave (
        input  m_valid, m_reg, m_val,
        output m_ready, m_done, m_nack
    );
endinterface

// File: rtl/sccb_delay_timer.sv
// Shared down-counter for power-up, inter-transaction gap and settle delays.
module sccb_delay_timer #(
    parameter int unsigned TMR_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TMR_W'(1);
        end
    end

    // Held high while the count sits at zero; masked in the load cycle.
    assign expired = (count == '0) && !load;

endmodule

// File: rtl/sccb_cfg_scheduler.sv
// Walks the OV7670 config ROM over a shared SCCB write master with settle delays
// and NACK retries, then arbitrates runtime single-register user writes.
module sccb_cfg_scheduler
    import ov7670_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 100000,
    parameter int unsigned SETTLE_CYCLES  = 100000,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TMR_W          = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic [7:0]           rom_addr,
    input  logic [15:0]          rom_data,
    input  logic                 usr_valid,
    output logic                 usr_ready,
    input  logic [7:0]           usr_reg,
    input  logic [7:0]           usr_val,
    sccb_cfg_scheduler_if.master m,
    output logic                 busy,
    output logic                 config_done,
    output logic                 error,
    output logic [7:0]           err_addr
);

    localparam int unsigned      RTY_W     = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [TMR_W-1:0] LD_PWRUP  = TMR_W'(POWERUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_GAP    = TMR_W'(GAP_CYCLES - 1);

    cfg_state_t       state;
    logic [RTY_W-1:0] retry;
    logic             rdy_q;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_exp;

    sccb_delay_timer #(.TMR_W(TMR_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // A same-cycle start takes priority over a pending user write.
    assign usr_ready = rdy_q & ~start;

    // config_done doubles as the phase flag: once set, transactions are user writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PWRUP;
            rom_addr    <= '0;
            m.m_valid   <= 1'b0;
            m.m_reg     <= '0;
            m.m_val     <= '0;
            busy        <= 1'b0;
            config_done <= 1'b0;
            error       <= 1'b0;
            err_addr    <= '0;
            rdy_q       <= 1'b0;
            retry       <= '0;
            tmr_load    <= 1'b1;
            tmr_val     <= LD_PWRUP;
        end else begin
            tmr_load <= 1'b0;
            if (start && (state == ST_DONE || state == ST_FAULT)) begin
                config_done <= 1'b0;
                error       <= 1'b0;
                retry       <= '0;
                rom_addr    <= '0;
                busy        <= 1'b1;
                rdy_q       <= 1'b0;
                state       <= ST_FETCH;
            end else begin
                case (state)
                    ST_PWRUP: begin
                        busy <= 1'b1;
                        if (tmr_exp) state <= ST_FETCH;
                    end
                    ST_FETCH: state <= ST_CHECK;
                    ST_CHECK: begin
                        if (rom_data == ROM_END) begin
                            config_done <= 1'b1;
                            busy        <= 1'b0;
                            rdy_q       <= 1'b1;
                            state       <= ST_DONE;
                        end else if (rom_data == ROM_DELAY) begin
                            if (rom_addr == '1) begin
                                error    <= 1'b1;
                                err_addr <= USR_ERR_ADDR;
                                busy     <= 1'b0;
                                state    <= ST_FAULT;
                            end else begin
                                rom_addr <= rom_addr + 8'd1;
                                tmr_load <= 1'b1;
                                tmr_val  <= LD_SETTLE;
                                state    <= ST_DELAY;
                            end
                        end else begin
                            m.m_reg   <= rom_data[15:8];
                            m.m_val   <= rom_data[7:0];
                            m.m_valid <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (m.m_ready) begin
                            m.m_valid <= 1'b0;
                            state     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (m.m_done) begin
                            if (!m.m_nack) begin
                                retry <= '0;
                                if (!config_done && rom_addr == '1) begin
                                    // Acked the last address with no terminator: the ROM ran off its end.
                                    error    <= 1'b1;
                                    err_addr <= USR_ERR_ADDR;
                                    busy     <= 1'b0;
                                    state    <= ST_FAULT;
                                end else begin
                                    if (!config_done) rom_addr <= rom_addr + 8'd1;
                                    tmr_load <= 1'b1;
                                    if (is_com7_reset(m.m_reg, m.m_val)) begin
                                        tmr_val <= LD_SETTLE;
                                        state   <= ST_DELAY;
                                    end else begin
                                        tmr_val <= LD_GAP;
                                        state   <= ST_GAP;
                                    end
                                end
                            end else if (retry < RTY_MAX) begin
                                retry    <= retry + RTY_W'(1);
                                tmr_load <= 1'b1;
                                tmr_val  <= LD_GAP;
                                state    <= ST_GAP;
                            end else begin
                                retry <= '0;
                                error <= 1'b1;
                                busy  <= 1'b0;
                                if (config_done) begin
                                    err_addr <= USR_ERR_ADDR;
                                    rdy_q    <= 1'b1;
                                    state    <= ST_DONE;
                                end else begin
                                    err_addr <= rom_addr;
                                    state    <= ST_FAULT;
                                end
                            end
                        end
                    end
                    ST_GAP: begin
                        if (tmr_exp) begin
                            if (!config_done) begin
                                state <= ST_FETCH;
                            end else if (retry != '0) begin
                                m.m_valid <= 1'b1;
                                state     <= ST_ISSUE;
                            end else begin
                                busy  <= 1'b0;
                                rdy_q <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (tmr_exp) begin
                            if (config_done) begin
                                busy  <= 1'b0;
                                rdy_q <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                state <= ST_FETCH;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (usr_valid && rdy_q) begin
                            m.m_reg   <= usr_reg;
                            m.m_val   <= usr_val;
                            m.m_valid <= 1'b1;
                            rdy_q     <= 1'b0;
                            busy      <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                    ST_FAULT: state <= ST_FAULT;
                    default: begin
                        busy  <= 1'b0;
                        rdy_q <= 1'b0;
                        state <= ST_FAULT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_cfg_scheduler.sv
// Scoreboard bench for sccb_cfg_scheduler: directed ROM images, a scripted SCCB master, user writes.
module tb_sccb_cfg_scheduler;

    logic        clk, reset_n, start, usr_valid, usr_ready, busy, config_done, error, stall;
    logic [7:0]  rom_addr, usr_reg, usr_val, err_addr, nack_reg;
    logic [15:0] rom_data;
    logic [15:0] rom [256];
    logic [15:0] sb [$];
    logic        pend_nack;
    int          errors = 0;
    int          checks = 0;
    int          nack_left = 0;
    int          pend = 0;
    int          n;

    sccb_cfg_scheduler_if bus ();

    sccb_cfg_scheduler #(
        .POWERUP_CYCLES (10),
        .SETTLE_CYCLES  (50),
        .GAP_CYCLES     (2),
        .MAX_RETRY      (3),
        .TMR_W          (20)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .usr_valid   (usr_valid),
        .usr_ready   (usr_ready),
        .usr_reg     (usr_reg),
        .usr_val     (usr_val),
        .m           (bus),
        .busy        (busy),
        .config_done (config_done),
        .error       (error),
        .err_addr    (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    assign bus.m_ready = ~stall;

    // SCCB master: completes each accepted request 3 cycles later; NACKs nack_reg while nack_left > 0.
    initial begin
        bus.m_done = 1'b0;
        bus.m_nack = 1'b0;
        pend_nack  = 1'b0;
        forever begin
            @(negedge clk);
            bus.m_done = 1'b0;
            bus.m_nack = 1'b0;
            if (reset_n !== 1'b1) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.m_done = 1'b1;
                        bus.m_nack = pend_nack;
                    end
                end
                if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                    pend      = 3;
                    pend_nack = (bus.m_reg == nack_reg) && (nack_left > 0);
                    if (pend_nack) nack_left--;
                end
            end
        end
    end

    initial begin
        logic [15:0] exp_w;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %02h/%02h, required no write", bus.m_reg, bus.m_val);
                end else begin
                    exp_w = sb.pop_front();
                    if ({bus.m_reg, bus.m_val} !== exp_w) begin
                        errors++;
                        $display("FAIL sb_write: got %02h/%02h, required %02h/%02h",
                                 bus.m_reg, bus.m_val, exp_w[15:8], exp_w[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] v);
        sb.push_back({r, v});
    endtask

    task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
        rom[3] = e3;
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return usr_ready === 1'b1 && busy === 1'b0;
            1:       return error === 1'b1 && busy === 1'b0;
            2:       return bus.m_valid === 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int what, input int limit, input string name);
        int k = 0;
        while (!cond(what) && k < limit) begin
            tick();
            k++;
        end
        checks++;
        if (!cond(what)) begin
            errors++;
            $display("FAIL %s: got timeout after %0d cycles, required condition %0d", name, k, what);
        end
    endtask

    task automatic count_to_valid(output int cnt, input int limit);
        cnt = 0;
        while (bus.m_valid !== 1'b1 && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; usr_valid = 1'b0; usr_reg = '0; usr_val = '0;
        stall = 1'b0; nack_reg = '0;
        load_rom(16'h1204, 16'h4010, 16'hFFFF, 16'hFFFF);
        repeat (3) tick();
        chk("rst_m_valid", {31'd0, bus.m_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_config_done", {31'd0, config_done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_err_addr", {24'd0, err_addr}, 0);
        chk("rst_rom_addr", {24'd0, rom_addr}, 0);
        chk("rst_usr_ready", {31'd0, usr_ready}, 0);

        // Basic walk with power-up wait
        push(8'h12, 8'h04); push(8'h40, 8'h10);
        reset_n = 1'b1;
        count_to_valid(n, 100);
        chk_range("pwrup_wait", n, 10, 15);
        wait_until(0, 2000, "t1_done");
        chk("t1_config_done", {31'd0, config_done}, 1);
        chk("t1_rom_addr", {24'd0, rom_addr}, 2);
        chk("t1_error", {31'd0, error}, 0);
        chk("t1_drain", sb.size(), 0);

        // Entry 1 NACKed three times, then acked
        nack_reg = 8'h40; nack_left = 3;
        push(8'h12, 8'h04);
        repeat (4) push(8'h40, 8'h10);
        pulse_start();
        chk("t3_restart_addr", {24'd0, rom_addr}, 0);
        chk("t3_restart_cfg", {31'd0, config_done}, 0);
        wait_until(0, 2000, "t3_done");
        chk("t3_error", {31'd0, error}, 0);
        chk("t3_config_done", {31'd0, config_done}, 1);
        chk("t3_rom_addr", {24'd0, rom_addr}, 2);
        chk("t3_drain", sb.size(), 0);

        // COM7 soft reset settle
        load_rom(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
        push(8'h12, 8'h80); push(8'h12, 8'h04);
        pulse_start();
        n = 0;
        while (!(bus.m_done === 1'b1 && bus.m_reg == 8'h12 && bus.m_val == 8'h80) && n < 500) begin
            tick();
            n++;
        end
        chk_range("t2_com7_done_seen", n, 0, 499);
        count_to_valid(n, 300);
        chk_range("settle_wait", n, 50, 60);
        wait_until(0, 2000, "t2_done");
        chk("t2_drain", sb.size(), 0);

        // Entry 2 always NACKed -> fault, then restart
        load_rom(16'h1204, 16'h4010, 16'h1180, 16'hFFFF);
        nack_reg = 8'h11; nack_left = 100;
        push(8'h12, 8'h04); push(8'h40, 8'h10);
        repeat (4) push(8'h11, 8'h80);
        pulse_start();
        wait_until(1, 2000, "t4_fault");
        chk("t4_error", {31'd0, error}, 1);
        chk("t4_err_addr", {24'd0, err_addr}, 2);
        chk("t4_config_done", {31'd0, config_done}, 0);
        chk("t4_usr_ready", {31'd0, usr_ready}, 0);
        chk("t4_drain", sb.size(), 0);
        nack_left = 0;
        push(8'h12, 8'h04); push(8'h40, 8'h10); push(8'h11, 8'h80);
        pulse_start();
        chk("t4_err_cleared", {31'd0, error}, 0);
        chk("t4_restart_addr", {24'd0, rom_addr}, 0);
        wait_until(0, 2000, "t4_rerun_done");
        chk("t4_rerun_cfg", {31'd0, config_done}, 1);
        chk("t4_rerun_addr", {24'd0, rom_addr}, 3);
        chk("t4_rerun_drain", sb.size(), 0);

        // Runtime user write
        push(8'h3A, 8'h04);
        usr_reg = 8'h3A; usr_val = 8'h04; usr_valid = 1'b1;
        tick();
        chk("usr_ready_drop", {31'd0, usr_ready}, 0);
        chk("usr_busy", {31'd0, busy}, 1);
        usr_valid = 1'b0;
        wait_until(0, 2000, "usr_done");
        chk("usr_config_done", {31'd0, config_done}, 1);
        chk("usr_error", {31'd0, error}, 0);
        chk("usr_drain", sb.size(), 0);

        // User write with exhausted retries
        nack_reg = 8'h55; nack_left = 100;
        repeat (4) push(8'h55, 8'h01);
        usr_reg = 8'h55; usr_val = 8'h01; usr_valid = 1'b1;
        tick();
        usr_valid = 1'b0;
        wait_until(0, 2000, "usr_nack_done");
        chk("usr_nack_error", {31'd0, error}, 1);
        chk("usr_nack_err_addr", {24'd0, err_addr}, 8'hFF);
        chk("usr_nack_cfg", {31'd0, config_done}, 1);
        chk("usr_nack_drain", sb.size(), 0);
        nack_left = 0;

        // start and usr_valid together: start wins
        push(8'h12, 8'h04); push(8'h40, 8'h10); push(8'h11, 8'h80);
        usr_reg = 8'h3A; usr_val = 8'h04; usr_valid = 1'b1; start = 1'b1;
        #1;
        chk("start_wins_ready", {31'd0, usr_ready}, 0);
        tick();
        start = 1'b0; usr_valid = 1'b0;
        chk("start_wins_err_clr", {31'd0, error}, 0);
        chk("start_wins_cfg_clr", {31'd0, config_done}, 0);
        wait_until(0, 2000, "start_wins_done");
        chk("start_wins_drain", sb.size(), 0);

        // ROM without terminator wraps -> fault
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'h20, 8'(i)};
            push(8'h20, 8'(i));
        end
        pulse_start();
        wait_until(1, 10000, "wrap_fault");
        chk("wrap_err_addr", {24'd0, err_addr}, 8'hFF);
        chk("wrap_error", {31'd0, error}, 1);
        chk("wrap_config_done", {31'd0, config_done}, 0);
        chk("wrap_drain", sb.size(), 0);

        // Reset during ISSUE
        load_rom(16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        stall = 1'b1;
        pulse_start();
        wait_until(2, 50, "t6_issue");
        reset_n = 1'b0;
        #1;
        chk("t6_async_m_valid", {31'd0, bus.m_valid}, 0);
        chk("t6_async_error", {31'd0, error}, 0);
        repeat (3) tick();
        stall = 1'b0;
        push(8'h12, 8'h04);
        reset_n = 1'b1;
        count_to_valid(n, 100);
        chk_range("t6_pwrup_wait", n, 10, 15);
        wait_until(0, 2000, "t6_done");
        chk("t6_config_done", {31'd0, config_done}, 1);
        chk("t6_drain", sb.size(), 0);

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sccb_cfg_scheduler.md
Name: sccb_cfg_scheduler

Overview:
Sequences OV7670 register configuration over a shared byte-level SCCB write master. It walks a configuration ROM, enforces power-up and soft-reset settle delays, and retries on NACK. After configuration it arbitrates runtime single-register writes from a user port onto the same master. It sits between the config ROM/user logic and the SCCB master that drives sioc/siod.

Parameters:
POWERUP_CYCLES, 100000, wait after reset release before the first write (1 ms at 100 MHz)
SETTLE_CYCLES, 100000, wait after a COM7 soft reset (0x12 with val[7]=1) or a ROM delay marker
GAP_CYCLES, 1000, idle gap between consecutive master transactions
MAX_RETRY, 3, NACK retries per entry before fault
TMR_W, 20, delay timer width; must hold max(POWERUP_CYCLES, SETTLE_CYCLES)

Ports:
clk  in  1  system clock, 100 MHz
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; restarts the sequence from ROM address 0 (DONE/FAULT only)
rom_addr  out  8  config ROM address
rom_data  in  16  {reg, val}; synchronous ROM, valid 1 cycle after rom_addr
usr_valid  in  1  runtime write request
usr_ready  out  1  scheduler accepts user write
usr_reg  in  8  user register address
usr_val  in  8  user register value
m_valid  out  1  transaction request to SCCB master
m_ready  in  1  master accepts the request
m_reg  out  8  register address to master
m_val  out  8  value to master
m_done  in  1  one-cycle pulse: transaction finished
m_nack  in  1  qualified by m_done; 1 = slave NACK
busy  out  1  a transaction or delay is in progress
config_done  out  1  ROM sequence completed successfully
error  out  1  sticky fault flag
err_addr  out  8  ROM address of the failing entry (0xFF for a user write)

Behaviour:
- Reset values: all outputs 0 except err_addr=0x00; state=PWRUP, timer=0, retry=0.
- States: PWRUP, FETCH, CHECK, ISSUE, WAIT, GAP, DELAY, DONE, FAULT.
- PWRUP: count POWERUP_CYCLES, then FETCH. busy=1.
- FETCH: rom_addr is held; wait 1 cycle for ROM latency, then CHECK.
- CHECK, by rom_data:
  - 0xFFFF: config_done<=1, go to DONE.
  - 0xFFF0 (delay marker): rom_addr++, go to DELAY.
  - Otherwise: latch m_reg/m_val, go to ISSUE.
- ISSUE: assert m_valid with m_reg/m_val stable until the cycle m_valid&&m_ready, then go to WAIT.
- WAIT: on m_done:
  - m_nack=0: retry<=0. If m_reg==0x12 and m_val[7]=1, go to DELAY; else go to GAP. rom_addr++ either way.
  - m_nack=1 and retry<MAX_RETRY: retry++, go to GAP, then re-ISSUE the same entry (rom_addr unchanged).
  - m_nack=1 and retry==MAX_RETRY: error<=1, err_addr<=rom_addr, go to FAULT.
- GAP: count GAP_CYCLES, then FETCH (config phase) or DONE (user phase).
- DELAY: count SETTLE_CYCLES, then FETCH.
- rom_addr wrap 0xFF->0x00 without a 0xFFFF terminator: treat as fault; err_addr=0xFF, error=1.
- DONE: busy=0; usr_ready=1.
  - On usr_valid&&usr_ready: latch usr_reg/usr_val, usr_ready drops the next cycle, ISSUE.
  - User writes use the same NACK/retry rules. On exhausted retries: error=1, err_addr=0xFF, return to DONE; config_done stays 1.
- usr_ready=0 in all states except DONE. usr_valid is never dropped by the scheduler: it stays pending until accepted.
- start:
  - Honoured only in DONE or FAULT: clears config_done, error and retry; rom_addr<=0; go to FETCH without the power-up wait.
  - Ignored elsewhere.
  - start and usr_valid in the same DONE cycle: start wins, usr_ready=0.
- m_done outside WAIT: ignored.
- Reset mid-transaction: async return to reset values. m_valid deasserts immediately; the master is expected to reset with the same reset_n.
- Timer: a single shared down-counter of TMR_W bits, loaded on state entry and exiting at 0.

Decomposition:
- Shared package ov7670_pkg:
  - state enum
  - ROM_END=16'hFFFF, ROM_DELAY=16'hFFF0
  - REG_COM7=8'h12, COM7_RESET_BIT=7
  - OV7670_WR_ID=8'h42
- One natural sub-module: sccb_delay_timer (load, count value, expired pulse), instanced once and shared by PWRUP/GAP/DELAY.

Test Plan:
1. ROM {1204, 4010, FFFF}, master always ACKs, POWERUP_CYCLES=10, GAP_CYCLES=2 -> first m_valid 10 cycles after reset release; writes (12,04) then (40,10) in order; config_done=1, rom_addr=2.
2. ROM {1280, 1204, FFFF}, SETTLE_CYCLES=50 -> m_valid for (12,04) no earlier than 50 cycles after the m_done of (12,80).
3. Master NACKs entry 1 three times then ACKs, MAX_RETRY=3 -> 4 issues of the same entry, then the sequence continues; error=0.
4. Master always NACKs entry 2 -> 4 issues, then error=1, err_addr=2, state FAULT; a start pulse re-runs from rom_addr=0 with error cleared.
5. After DONE: usr_valid with reg 0x3A, val 0x04 -> usr_ready handshake, m_reg=0x3A, m_val=0x04; start and usr_valid in the same cycle -> no user write issued.
6. Assert reset_n=0 during ISSUE -> m_valid=0 in the same cycle; after release the sequence restarts with the power-up wait.
